// File: rtl/platform_spawner.sv
// Scrolls NUM_PLAT platforms down once per frame tick, one per cycle,
// respawning any that fall past the bottom line at the top with a random x.
module platform_spawner #(
  parameter int NUM_PLAT     = 4,
  parameter int VBP          = 31,
  parameter int VFP          = 511,
  parameter int HBP          = 325,
  parameter int PLAT_SPACING = 120,
  parameter int HSTEP        = 50
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [9:0]             rand_hpos,
  input  logic                   scroll_tick,
  input  logic [3:0]             scroll_amt,
  output logic [NUM_PLAT*10-1:0] plat_hpos_flat,
  output logic [NUM_PLAT*10-1:0] plat_vpos_flat,
  output logic                   respawn_pulse,
  output logic                   update_done,
  output logic                   busy,
  output logic [15:0]            respawn_count
);

  localparam int IDXW = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    DONE
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [9:0]      hpos_q [NUM_PLAT];
  logic [9:0]      vpos_q [NUM_PLAT];
  logic [IDXW-1:0] idx_q;
  logic [3:0]      amt_q;
  logic [10:0]     sum;
  logic            hit;
  logic            last;

  // 11-bit sum so a 10-bit position plus the scroll can never wrap
  assign sum  = {1'b0, vpos_q[idx_q]} + {7'd0, amt_q};
  assign hit  = sum > 11'(VFP);
  assign last = idx_q == IDXW'(NUM_PLAT - 1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (scroll_tick) state_d = UPDATE;
      UPDATE: if (last) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      amt_q         <= '0;
      respawn_pulse <= 1'b0;
      update_done   <= 1'b0;
      busy          <= 1'b0;
      respawn_count <= '0;
      for (int i = 0; i < NUM_PLAT; i++) begin
        hpos_q[i] <= 10'(HBP + i * HSTEP);
        vpos_q[i] <= 10'(VBP + i * PLAT_SPACING);
      end
    end else begin
      state_q       <= state_d;
      respawn_pulse <= 1'b0;
      update_done   <= state_d == DONE;
      busy          <= state_d != IDLE;
      unique case (state_q)
        IDLE: begin
          if (scroll_tick) begin
            amt_q <= scroll_amt;
            idx_q <= '0;
          end
        end
        UPDATE: begin
          if (hit) begin
            vpos_q[idx_q] <= 10'(VBP);
            hpos_q[idx_q] <= rand_hpos;
            respawn_pulse <= 1'b1;
            respawn_count <= respawn_count + 16'd1;
          end else begin
            vpos_q[idx_q] <= sum[9:0];
          end
          if (!last) idx_q <= idx_q + IDXW'(1);
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_PLAT; g++) begin : g_flat
    assign plat_hpos_flat[g*10 +: 10] = hpos_q[g];
    assign plat_vpos_flat[g*10 +: 10] = vpos_q[g];
  end

endmodule

// File: tb/tb_platform_spawner.sv
// Directed bench for platform_spawner: scroll passes, respawn edges,
// dropped ticks and asynchronous reset mid-pass.
module tb_platform_spawner;

  logic        clk;
  logic        rst;
  logic [9:0]  rand_hpos;
  logic        scroll_tick;
  logic [3:0]  scroll_amt;
  logic [39:0] plat_hpos_flat;
  logic [39:0] plat_vpos_flat;
  logic        respawn_pulse;
  logic        update_done;
  logic        busy;
  logic [15:0] respawn_count;

  int checks = 0;
  int errors = 0;

  int ev [4];
  int eh [4];
  int ecnt;

  platform_spawner dut (
    .clk           (clk),
    .rst           (rst),
    .rand_hpos     (rand_hpos),
    .scroll_tick   (scroll_tick),
    .scroll_amt    (scroll_amt),
    .plat_hpos_flat(plat_hpos_flat),
    .plat_vpos_flat(plat_vpos_flat),
    .respawn_pulse (respawn_pulse),
    .update_done   (update_done),
    .busy          (busy),
    .respawn_count (respawn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int vp(input int k);
    return int'(plat_vpos_flat[k*10 +: 10]);
  endfunction

  function automatic int hp(input int k);
    return int'(plat_hpos_flat[k*10 +: 10]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      ev[k] = 31 + k * 120;
      eh[k] = 325 + k * 50;
    end
    ecnt = 0;
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s vpos%0d", tag, k), vp(k), ev[k]);
      chk($sformatf("%s hpos%0d", tag, k), hp(k), eh[k]);
    end
    chk({tag, " count"}, int'(respawn_count), ecnt & 16'hFFFF);
  endtask

  // One full pass; platform k sees rand_hpos = hbase + 7k in its cycle.
  // dup injects a second tick two cycles after the first.
  task automatic do_pass(input int amt, input int hbase, input bit dup);
    int fl [4];
    int s;
    for (int k = 0; k < 4; k++) begin
      s = ev[k] + amt;
      if (s > 511) begin
        ev[k] = 31;
        eh[k] = hbase + k * 7;
        fl[k] = 1;
        ecnt++;
      end else begin
        ev[k] = s;
        fl[k] = 0;
      end
    end
    scroll_tick = 1'b1;
    scroll_amt  = 4'(amt);
    @(negedge clk);
    scroll_tick = 1'b0;
    scroll_amt  = 4'd0;
    for (int k = 0; k < 4; k++) begin
      rand_hpos = 10'(hbase + k * 7);
      if (dup && k == 1) begin
        scroll_tick = 1'b1;
        scroll_amt  = 4'd9;
      end else begin
        scroll_tick = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("pulse%0d", k), int'(respawn_pulse), fl[k]);
      chk($sformatf("busy%0d", k), int'(busy), 1);
    end
    chk("done_hi", int'(update_done), 1);
    chk("busy_done", int'(busy), 1);
    @(negedge clk);
    chk("done_lo", int'(update_done), 0);
    chk("busy_lo", int'(busy), 0);
    check_all("pass");
  endtask

  initial begin
    rst         = 1'b1;
    rand_hpos   = 10'd0;
    scroll_tick = 1'b0;
    scroll_amt  = 4'd0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset values
    chk("rst v0", vp(0), 31);
    chk("rst v1", vp(1), 151);
    chk("rst v2", vp(2), 271);
    chk("rst v3", vp(3), 391);
    chk("rst h0", hp(0), 325);
    chk("rst h3", hp(3), 475);
    chk("rst cnt", int'(respawn_count), 0);
    chk("rst busy", int'(busy), 0);

    // plain scroll by 5
    do_pass(5, 330, 1'b0);
    chk("s5 v0", vp(0), 36);
    chk("s5 v1", vp(1), 156);
    chk("s5 v2", vp(2), 276);
    chk("s5 v3", vp(3), 396);
    chk("s5 cnt", int'(respawn_count), 0);

    // walk p0 to 509: 36 + 31*15 + 8
    for (int i = 0; i < 31; i++) do_pass(15, 340 + i, 1'b0);
    do_pass(8, 380, 1'b0);
    chk("pre v0", vp(0), 509);

    // 509 + 5 respawns p0 with x = 400
    do_pass(5, 400, 1'b0);
    chk("rsp v0", vp(0), 31);
    chk("rsp h0", hp(0), 400);

    // walk p0 to 507: 31 + 31*15 + 11
    for (int i = 0; i < 31; i++) do_pass(15, 420 + i, 1'b0);
    do_pass(11, 460, 1'b0);
    chk("pre2 v0", vp(0), 507);
    do_pass(4, 470, 1'b0);
    chk("eq v0", vp(0), 511);
    do_pass(1, 480, 1'b0);
    chk("gt v0", vp(0), 31);
    chk("gt h0", hp(0), 480);

    // tick while busy is dropped
    do_pass(2, 490, 1'b1);
    @(negedge clk);
    chk("dup idle", int'(busy), 0);
    check_all("dup");

    // amt 0 pass leaves everything in place
    do_pass(0, 500, 1'b0);

    // async reset while idx = 2
    scroll_tick = 1'b1;
    scroll_amt  = 4'd7;
    @(negedge clk);
    scroll_tick = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("arst");
    chk("arst busy", int'(busy), 0);
    chk("arst pulse", int'(respawn_pulse), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("arst done", int'(update_done), 0);
    do_pass(3, 510, 1'b0);
    chk("post v0", vp(0), 34);
    chk("post v1", vp(1), 154);
    chk("post v2", vp(2), 274);
    chk("post v3", vp(3), 394);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
